// File: rtl/des3_sequencer.sv
// des3_sequencer: drives a single-DES round core through three passes
// (EDE) per 64-bit block, chaining each pass's result into the next one.
module des3_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_dir,
    input  logic [64:1] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] out_data,
    output logic [5:1]  core_counter,
    output logic        core_mode,
    output logic [2:1]  core_key_sel,
    output logic [64:1] core_data_in,
    input  logic [64:1] core_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [5:1] CNT_LOAD = 5'd1;
    localparam logic [5:1] CNT_LAST = 5'd17;
    localparam logic [2:1] PASS_LAST = 2'd2;

    state_t      state_q, state_d;
    logic [64:1] work_q, work_d;
    logic        dir_q, dir_d;
    logic [2:1]  pass_q, pass_d;
    logic [5:1]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [64:1] out_data_q, out_data_d;
    logic        mode_q, mode_d;
    logic [2:1]  key_sel_q, key_sel_d;

    // Next-state: accept a block, step the round counter, chain passes, hold the result.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        dir_d       = dir_q;
        pass_d      = pass_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mode_d      = mode_q;
        key_sel_d   = key_sel_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d    = in_data;
                    dir_d     = in_dir;
                    pass_d    = '0;
                    cnt_d     = CNT_LOAD;
                    mode_d    = in_dir;
                    key_sel_d = in_dir ? 2'd3 : 2'd1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    work_d = core_data_out;
                    if (pass_q != PASS_LAST) begin
                        // Middle pass runs the opposite direction; keys walk K1->K3 or K3->K1.
                        pass_d    = pass_q + 2'd1;
                        cnt_d     = CNT_LOAD;
                        mode_d    = ~mode_q;
                        key_sel_d = dir_q ? (key_sel_q - 2'd1) : (key_sel_q + 2'd1);
                    end else begin
                        out_data_d  = core_data_out;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            dir_q       <= 1'b0;
            pass_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            mode_q      <= 1'b0;
            key_sel_q   <= 2'd1;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            dir_q       <= dir_d;
            pass_q      <= pass_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            mode_q      <= mode_d;
            key_sel_q   <= key_sel_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        in_ready     = (state_q == IDLE);
        core_counter = (state_q == RUN) ? cnt_q : '0;
        core_mode    = mode_q;
        core_key_sel = key_sel_q;
        core_data_in = work_q;
        out_valid    = out_valid_q;
        out_data     = out_data_q;
    end

endmodule
